// File: rtl/secmem_pkg.sv
// secmem_pkg: shared widths, mask byte and scanner state type for the secure memory path.
package secmem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] MASK_BYTE = 8'h3F;
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, DONE} scan_state_t;
endpackage

// File: rtl/secmem_scanner.sv
// secmem_scanner: sweeps secure_memory over an address range and hands each settled byte downstream.
module secmem_scanner
  import secmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_FIRST = 5'd0,
  parameter logic [ADDR_W-1:0] ADDR_LAST = 5'd31,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_value,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count
);
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("secmem_scanner: SETTLE must lie in 1..15");
  end
  // The parameter SETTLE hides the state of the same name, so the state is reached through the package.
  localparam scan_state_t S_SETTLE = secmem_pkg::SETTLE;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
  scan_state_t state, state_n;
  logic [3:0] cnt;
  logic last, go, smp, hs;
  always_comb begin
    last = mem_address == ADDR_LAST;
    go = !abort && state == IDLE && start;
    smp = !abort && state == S_SETTLE && cnt == 4'd0;
    hs = !abort && state == PRESENT && out_ready;
    state_n = abort ? IDLE :
              go ? S_SETTLE :
              smp ? PRESENT :
              hs ? (last ? DONE : S_SETTLE) :
              state == DONE ? IDLE : state;
  end
  assign out_valid = state == PRESENT;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      cnt <= '0;
      out_data <= '0;
      out_addr <= '0;
      byte_count <= '0;
    end else begin
      if (go || (hs && !last)) begin
        mem_address <= go ? ADDR_FIRST : mem_address + 1'b1;
        cnt <= CNT_INIT;
      end else if (!abort && state == S_SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (smp) begin
        out_data <= mem_value;
        out_addr <= mem_address;
      end
      if (go || hs) byte_count <= go ? '0 : byte_count + 6'd1;
    end
  end
endmodule

// File: tb/tb_secmem_scanner.sv
// tb_secmem_scanner: vector table, directed sweeps and randomized sweeps against a memory model.
module tb_secmem_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [4];
  logic abort [4];
  logic ready [4];
  logic valid [4];
  logic busy [4];
  logic done [4];
  logic [4:0] maddr [4];
  logic [4:0] oaddr [4];
  logic [7:0] odata [4];
  logic [7:0] mem_value [4];
  logic [5:0] bc [4];
  logic [7:0] rom [4][32];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // instance 2 sees the new byte two clocks after an address change, instance 3 combinationally
  for (genvar g = 0; g < 4; g++) begin : g_mem
    logic [7:0] p1, p2;
    always @(posedge clk) begin
      p1 <= rom[g][maddr[g]];
      p2 <= p1;
    end
    assign mem_value[g] = g == 2 ? p2 : g == 3 ? rom[g][maddr[g]] : p1;
  end

  secmem_scanner #(.ADDR_FIRST(5'd0), .ADDR_LAST(5'd31), .SETTLE(2)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .mem_address(maddr[0]),
    .mem_value(mem_value[0]), .out_data(odata[0]), .out_addr(oaddr[0]), .out_valid(valid[0]),
    .out_ready(ready[0]), .busy(busy[0]), .done(done[0]), .byte_count(bc[0]));
  secmem_scanner #(.ADDR_FIRST(5'd30), .ADDR_LAST(5'd1), .SETTLE(2)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .mem_address(maddr[1]),
    .mem_value(mem_value[1]), .out_data(odata[1]), .out_addr(oaddr[1]), .out_valid(valid[1]),
    .out_ready(ready[1]), .busy(busy[1]), .done(done[1]), .byte_count(bc[1]));
  secmem_scanner #(.ADDR_FIRST(5'd0), .ADDR_LAST(5'd3), .SETTLE(3)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .mem_address(maddr[2]),
    .mem_value(mem_value[2]), .out_data(odata[2]), .out_addr(oaddr[2]), .out_valid(valid[2]),
    .out_ready(ready[2]), .busy(busy[2]), .done(done[2]), .byte_count(bc[2]));
  secmem_scanner #(.ADDR_FIRST(5'd7), .ADDR_LAST(5'd7), .SETTLE(1)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .mem_address(maddr[3]),
    .mem_value(mem_value[3]), .out_data(odata[3]), .out_addr(oaddr[3]), .out_valid(valid[3]),
    .out_ready(ready[3]), .busy(busy[3]), .done(done[3]), .byte_count(bc[3]));

  typedef struct {
    logic st, ab, rd, ev, eb, ed;
    logic [4:0] em, eo;
    logic [7:0] edt;
    logic [5:0] ebc;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bytes come from a snapshot of the memory image taken when the sweep starts.
  task automatic sweep(input int k, input int first, input int last, input int settle,
                       input bit rnd, input int bp);
    int n, i, prev, cyc;
    bit held, bp_done;
    logic [7:0] snap [32];
    logic [4:0] a;
    n = ((last - first + 32) % 32) + 1;
    for (int j = 0; j < 32; j++) snap[j] = rom[k][j];
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    chk($sformatf("d%0d_start_busy", k), busy[k], 1);
    chk($sformatf("d%0d_start_addr", k), maddr[k], first);
    chk($sformatf("d%0d_start_bc", k), bc[k], 0);
    i = 0; prev = 0; cyc = 0; bp_done = 0;
    while (i < n && cyc < 3000) begin
      held = 0;
      ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) start[k] = 1'($urandom_range(0, 3) == 0);
      chk($sformatf("d%0d_no_early_done", k), done[k], 0);
      if (bp >= 0 && !bp_done && valid[k] && oaddr[k] == 5'(bp)) begin
        bp_done = 1; held = 1;
        ready[k] = 1'b0;
        rom[k][bp] = 8'hAA;
        for (int t = 0; t < 10; t++) begin
          tick(); cyc++;
          chk("bp_valid", valid[k], 1);
          chk("bp_out_addr", oaddr[k], bp);
          chk("bp_out_data", odata[k], snap[bp]);
          chk("bp_mem_address", maddr[k], bp);
        end
        rom[k][bp] = snap[bp];
        ready[k] = 1'b1;
      end
      if (valid[k] && ready[k]) begin
        a = 5'(first + i);
        chk($sformatf("d%0d_hs%0d_addr", k, i), oaddr[k], a);
        chk($sformatf("d%0d_hs%0d_data", k, i), odata[k], snap[a]);
        chk($sformatf("d%0d_hs%0d_bc", k, i), bc[k], i);
        if (!rnd && !held) chk($sformatf("d%0d_hs%0d_spacing", k, i), cyc + 1 - prev, settle + 1);
        prev = cyc + 1;
        i++;
      end
      tick(); cyc++;
    end
    start[k] = 1'b0;
    ready[k] = 1'b0;
    chk($sformatf("d%0d_hs_count", k), i, n);
    chk($sformatf("d%0d_done_pulse", k), done[k], 1);
    chk($sformatf("d%0d_done_bc", k), bc[k], n);
    chk($sformatf("d%0d_done_valid", k), valid[k], 0);
    tick();
    chk($sformatf("d%0d_after_done", k), done[k], 0);
    chk($sformatf("d%0d_after_busy", k), busy[k], 0);
    chk($sformatf("d%0d_after_bc", k), bc[k], n);
  endtask

  initial begin
    int t;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; ready[k] = 1'b0;
      for (int j = 0; j < 32; j++) rom[k][j] = 8'h3F;
    end
    rom[0][31] = 8'h7D;
    rom[1][31] = 8'h7D;
    for (int j = 0; j < 32; j++) rom[2][j] = 8'(j) ^ 8'hA5;
    rom[3][7] = 8'h5C;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 6'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 6'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 6'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 8'h00, 6'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 8'h3F, 6'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 8'h3F, 6'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 8'h3F, 6'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0, 8'h3F, 6'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 5'd1, 8'h3F, 6'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd1, 8'h3F, 6'd1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 8'h3F, 6'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 8'h3F, 6'd0};
    #12;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst%0d_mem_address", k), maddr[k], 0);
      chk($sformatf("rst%0d_out_data", k), odata[k], 0);
      chk($sformatf("rst%0d_out_addr", k), oaddr[k], 0);
      chk($sformatf("rst%0d_valid", k), valid[k], 0);
      chk($sformatf("rst%0d_busy", k), busy[k], 0);
      chk($sformatf("rst%0d_done", k), done[k], 0);
      chk($sformatf("rst%0d_bc", k), bc[k], 0);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      start[0] = tbl[i].st; abort[0] = tbl[i].ab; ready[0] = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_valid", i), valid[0], tbl[i].ev);
      chk($sformatf("tbl%0d_busy", i), busy[0], tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), done[0], tbl[i].ed);
      chk($sformatf("tbl%0d_mem_address", i), maddr[0], tbl[i].em);
      chk($sformatf("tbl%0d_out_addr", i), oaddr[0], tbl[i].eo);
      chk($sformatf("tbl%0d_out_data", i), odata[0], tbl[i].edt);
      chk($sformatf("tbl%0d_bc", i), bc[0], tbl[i].ebc);
    end
    start[0] = 1'b0; abort[0] = 1'b0; ready[0] = 1'b0;
    tick();
    sweep(0, 0, 31, 2, 0, -1);
    tick();
    sweep(0, 0, 31, 2, 0, 5);
    tick();
    sweep(1, 30, 1, 2, 0, -1);
    sweep(2, 0, 3, 3, 0, -1);
    sweep(3, 7, 7, 1, 0, -1);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    ready[0] = 1'b1;
    t = 0;
    while (!(valid[0] && oaddr[0] == 5'd10) && t < 200) begin
      tick(); t++;
    end
    chk("abort_reached_addr10", valid[0] && oaddr[0] == 5'd10, 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0; ready[0] = 1'b0;
    chk("abort_valid", valid[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_bc", bc[0], 10);
    chk("abort_mem_address", maddr[0], 10);
    for (int j = 0; j < 5; j++) begin
      chk("abort_done", done[0], 0);
      tick();
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("restart_mem_address", maddr[0], 0);
    chk("restart_bc", bc[0], 0);
    chk("restart_busy", busy[0], 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    for (int j = 0; j < 32; j++) begin
      rom[0][j] = 8'($urandom);
      rom[1][j] = 8'($urandom);
    end
    sweep(0, 0, 31, 2, 1, -1);
    sweep(1, 30, 1, 2, 1, -1);
    for (int j = 0; j < 32; j++) rom[0][j] = 8'h3F;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    ready[0] = 1'b1;
    t = 0;
    while (!(maddr[0] == 5'd3 && !valid[0]) && t < 200) begin
      tick(); t++;
    end
    chk("rst_mid_reached", maddr[0] == 5'd3 && !valid[0], 1);
    ready[0] = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_address", maddr[0], 0);
    chk("rst_mid_out_data", odata[0], 0);
    chk("rst_mid_out_addr", oaddr[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_bc", bc[0], 0);
    start[0] = 1'b1;
    tick();
    chk("rst_held_busy", busy[0], 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("rst_release_busy", busy[0], 1);
    chk("rst_release_mem_address", maddr[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
